// File: rtl/pic_ack_sequencer.sv
// ---------------------------------------------------------------------------
// pic_ack_sequencer
//
// Interrupt acknowledge sequencer for an 8259-style PIC. Raises INT toward
// the CPU when the priority resolver presents a request, then walks the CPU
// INTA pulse train (two pulses in 8086 mode, three in 8080 mode). It decides
// on which pulses this PIC drives the data bus and which byte it drives. It
// also handles cascade addressing for a master and bus gating for a slave.
//
// Ports
//   clk              clock, all logic on the rising edge
//   reset            synchronous, active-high reset
//   INTA             CPU acknowledge strobe, active-low
//   INT_request      level request from the priority resolver
//   interrupt_index  winning IR index from the priority resolver
//   mode_8086        1 = two-pulse sequence, 0 = three-pulse (8080)
//   single           1 = stand-alone PIC, no cascade
//   SP               1 = master, 0 = slave
//   ICW3             master: IR lines that have a slave attached
//   cascade_match    slave: CAS lines equal this PIC's ID
//   auto_eoi         automatic EOI enable
//   EOI              one-cycle EOI command pulse
//   rw_busy          register read/write logic is active
//   INT              interrupt to the CPU
//   freezing         freeze IRR while an acknowledge is in progress
//   latch_isr        one-cycle pulse: set ISR bit isr_index
//   isr_index        IR index captured at the first INTA fall
//   vec_en           this PIC drives the data bus
//   vec_byte         0 = CALL opcode, 1 = vector/low address, 2 = high address
//   cascade_en       master drives the CAS lines
//   desired_slave    value driven on the CAS lines
//   auto_eoi_clr     one-cycle pulse: clear ISR bit isr_index
//   EOI_to_cascade   EOI delayed by one cycle
// ---------------------------------------------------------------------------
module pic_ack_sequencer #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               INTA,
    input  logic               INT_request,
    input  logic [IDX_W-1:0]   interrupt_index,
    input  logic               mode_8086,
    input  logic               single,
    input  logic               SP,
    input  logic [NUM_IRQ-1:0] ICW3,
    input  logic               cascade_match,
    input  logic               auto_eoi,
    input  logic               EOI,
    input  logic               rw_busy,
    output logic               INT,
    output logic               freezing,
    output logic               latch_isr,
    output logic [IDX_W-1:0]   isr_index,
    output logic               vec_en,
    output logic [1:0]         vec_byte,
    output logic               cascade_en,
    output logic [IDX_W-1:0]   desired_slave,
    output logic               auto_eoi_clr,
    output logic               EOI_to_cascade
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ACK  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Index reported for an acknowledge that arrives with nothing pending.
    localparam logic [IDX_W-1:0] SPUR_IDX = IDX_W'(NUM_IRQ - 1);

    state_t           state_q, state_d;
    logic             inta_q, inta_d;
    logic [1:0]       pulse_cnt_q, pulse_cnt_d;
    logic [IDX_W-1:0] isr_index_q, isr_index_d;
    logic             spurious_q, spurious_d;
    logic             latch_q, latch_d;
    logic             casc_q, casc_d;
    logic [IDX_W-1:0] slave_id_q, slave_id_d;
    logic             match_q, match_d;
    logic             eoi_q, eoi_d;

    logic             inta_fall;
    logic             inta_rise;
    logic [1:0]       last_cnt;
    logic             vector_pulse;
    logic             call_pulse;
    logic             bus_allowed;
    logic             is_slave;

    assign inta_fall = inta_q & ~INTA;
    assign inta_rise = ~inta_q & INTA;
    assign last_cnt  = mode_8086 ? 2'd1 : 2'd2;
    assign is_slave  = ~single & ~SP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            inta_q      <= 1'b1;
            pulse_cnt_q <= 2'd0;
            isr_index_q <= '0;
            spurious_q  <= 1'b0;
            latch_q     <= 1'b0;
            casc_q      <= 1'b0;
            slave_id_q  <= '0;
            match_q     <= 1'b0;
            eoi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_q      <= inta_d;
            pulse_cnt_q <= pulse_cnt_d;
            isr_index_q <= isr_index_d;
            spurious_q  <= spurious_d;
            latch_q     <= latch_d;
            casc_q      <= casc_d;
            slave_id_q  <= slave_id_d;
            match_q     <= match_d;
            eoi_q       <= eoi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        inta_d      = INTA;
        pulse_cnt_d = pulse_cnt_q;
        isr_index_d = isr_index_q;
        spurious_d  = spurious_q;
        latch_d     = 1'b0;
        casc_d      = casc_q;
        slave_id_d  = slave_id_q;
        match_d     = match_q;
        eoi_d       = EOI;

        case (state_q)
            S_IDLE: begin
                if (inta_fall) begin
                    // Acknowledge with nothing pending: run the bus cycle
                    // but never touch the ISR.
                    state_d     = S_ACK;
                    pulse_cnt_d = 2'd0;
                    isr_index_d = SPUR_IDX;
                    spurious_d  = 1'b1;
                    casc_d      = ~single & SP & ICW3[SPUR_IDX];
                    slave_id_d  = (~single & SP & ICW3[SPUR_IDX]) ? SPUR_IDX : '0;
                    match_d     = cascade_match;
                end else if (INT_request && !rw_busy) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // A fall wins over a simultaneous request drop: the CPU has
                // already committed to the acknowledge.
                if (inta_fall) begin
                    state_d     = S_ACK;
                    pulse_cnt_d = 2'd0;
                    isr_index_d = interrupt_index;
                    spurious_d  = 1'b0;
                    latch_d     = 1'b1;
                    casc_d      = ~single & SP & ICW3[interrupt_index];
                    slave_id_d  = (~single & SP & ICW3[interrupt_index]) ? interrupt_index : '0;
                    match_d     = cascade_match;
                end else if (EOI || !INT_request) begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                if (inta_fall) begin
                    pulse_cnt_d = pulse_cnt_q + 2'd1;
                    match_d     = cascade_match;
                end else if (inta_rise && pulse_cnt_q == last_cnt) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                casc_d     = 1'b0;
                slave_id_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus-drive qualification for the pulse currently in progress.
    always_comb begin
        vector_pulse = mode_8086 ? (pulse_cnt_q == 2'd1) : 1'b1;
        call_pulse   = ~mode_8086 & (pulse_cnt_q == 2'd0);
        bus_allowed  = 1'b1;
        if (casc_q) begin
            // The addressed slave supplies everything except the CALL opcode.
            bus_allowed = call_pulse;
        end else if (is_slave) begin
            bus_allowed = ~call_pulse & match_q;
        end
    end

    // Both the raw and the registered strobe must be low, so a new pulse is
    // not driven with the previous pulse's count before the fall registers.
    assign vec_en         = (state_q == S_ACK) & ~INTA & ~inta_q & vector_pulse & bus_allowed;
    assign vec_byte       = (state_q == S_ACK) ? (mode_8086 ? 2'd1 : pulse_cnt_q) : 2'd0;
    assign INT            = (state_q == S_REQ);
    assign freezing       = (state_q == S_ACK);
    assign latch_isr      = latch_q;
    assign isr_index      = isr_index_q;
    assign cascade_en     = casc_q;
    assign desired_slave  = slave_id_q;
    assign auto_eoi_clr   = (state_q == S_DONE) & auto_eoi & ~spurious_q;
    assign EOI_to_cascade = eoi_q;

endmodule
